// File: rtl/div_pkg.sv
// Shared types and defaults for the EX-stage divide requester.
package div_pkg;

  localparam int unsigned DIV_CYCLE_DEFAULT = 34;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DRAIN,
    HOLD
  } div_state_t;

  typedef struct packed {
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        sign;
    logic        dividend_sign;
  } div_req_t;

  function automatic logic [31:0] mag32(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/div_operand_prep.sv
// Converts DIV/DIVU operands into magnitudes plus the sign-fix flags the divider needs.
module div_operand_prep
  import div_pkg::*;
(
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  input  logic        i_signed,
  output div_req_t    o_req
);

  always_comb begin
    o_req = '0;
    if (i_signed) begin
      o_req.dividend      = mag32(i_rs);
      o_req.divisor       = mag32(i_rt);
      o_req.sign          = i_rs[31] ^ i_rt[31];
      o_req.dividend_sign = i_rs[31];
    end else begin
      o_req.dividend = i_rs;
      o_req.divisor  = i_rt;
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// EX-stage divide requester: issues the divider, stalls the pipe, and returns
// quotient/remainder as a one-cycle HI/LO write, with flush, hold and watchdog handling.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int unsigned DIV_CYCLE = DIV_CYCLE_DEFAULT,
  parameter int unsigned WD_SLACK  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_div_valid,
  input  logic        ex_div_signed,
  input  logic [31:0] ex_rs,
  input  logic [31:0] ex_rt,
  input  logic        ex_flush,
  input  logic        pipe_hold,
  input  logic        div_done,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  output logic        div_begin,
  output logic        div_sign,
  output logic        div_dividend_sign,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic        div_stall,
  output logic        res_valid,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_timeout
);

  localparam int unsigned WD_LIMIT = DIV_CYCLE + 2 + WD_SLACK;
  localparam int unsigned WD_W     = $clog2(WD_LIMIT + 1);

  div_state_t      r_state;
  div_state_t      w_state_nxt;
  div_req_t        w_req;
  div_req_t        r_req;
  logic            r_begin;
  logic [31:0]     r_hi;
  logic [31:0]     r_lo;
  logic [WD_W-1:0] r_wd;
  logic            r_timeout;

  logic            w_issue;
  logic            w_capture;
  logic            w_stall;
  logic            w_res_valid;
  logic [31:0]     w_res_hi;
  logic [31:0]     w_res_lo;
  logic            w_wd_enter;
  logic            w_wd_stay;

  div_operand_prep u_prep (
    .i_rs     (ex_rs),
    .i_rt     (ex_rt),
    .i_signed (ex_div_signed),
    .o_req    (w_req)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_capture   = 1'b0;
    w_stall     = 1'b0;
    w_res_valid = 1'b0;
    w_res_hi    = '0;
    w_res_lo    = '0;
    unique case (r_state)
      IDLE: begin
        if (ex_div_valid && !ex_flush) begin
          w_issue     = 1'b1;
          w_stall     = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        w_stall = 1'b1;
        if (ex_flush) begin
          w_state_nxt = div_done ? IDLE : DRAIN;
        end else if (div_done) begin
          // EX is released either way: pipe_hold already freezes it when set.
          w_stall = 1'b0;
          if (pipe_hold) begin
            w_capture   = 1'b1;
            w_state_nxt = HOLD;
          end else begin
            w_res_valid = 1'b1;
            w_res_hi    = div_remainder;
            w_res_lo    = div_quotient;
            w_state_nxt = IDLE;
          end
        end
      end
      DRAIN: begin
        w_stall = ex_div_valid;
        if (div_done) begin
          w_state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (ex_flush) begin
          w_state_nxt = IDLE;
        end else if (!pipe_hold) begin
          w_res_valid = 1'b1;
          w_res_hi    = r_hi;
          w_res_lo    = r_lo;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_wd_enter = ((w_state_nxt == BUSY) || (w_state_nxt == DRAIN)) && (w_state_nxt != r_state);
  assign w_wd_stay  = ((r_state == BUSY) || (r_state == DRAIN)) && (w_state_nxt == r_state);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_req     <= '0;
      r_begin   <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_begin <= w_issue;
      if (w_issue) begin
        r_req <= w_req;
      end
      if (w_capture) begin
        r_hi <= div_remainder;
        r_lo <= div_quotient;
      end
      // Entry counts as the first cycle, so r_wd equals cycles since issue.
      if (w_wd_enter) begin
        r_wd <= WD_W'(1);
      end else if (w_wd_stay && (r_wd != WD_W'(WD_LIMIT))) begin
        r_wd <= r_wd + WD_W'(1);
        if (r_wd == WD_W'(WD_LIMIT - 1)) begin
          r_timeout <= 1'b1;
        end
      end
    end
  end

  assign div_begin         = r_begin;
  assign div_sign          = r_req.sign;
  assign div_dividend_sign = r_req.dividend_sign;
  assign div_dividend      = r_req.dividend;
  assign div_divisor       = r_req.divisor;
  assign div_timeout       = r_timeout;

  // Combinational outputs are forced low while rst is held, not only after the edge.
  assign div_stall = w_stall & ~rst;
  assign res_valid = w_res_valid & ~rst;
  assign res_hi    = rst ? '0 : w_res_hi;
  assign res_lo    = rst ? '0 : w_res_lo;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: emulates the divider and checks cycle-level behaviour
// against arithmetic expectations derived from the operation timeline.
module tb_div_issue_ctrl;

  localparam int DIVC   = 34;
  localparam int SLACK  = 4;
  localparam int DONE_C = DIVC + 2;
  localparam int WD_C   = DIVC + 2 + SLACK;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_div_valid = 1'b0;
  logic        ex_div_signed = 1'b0;
  logic [31:0] ex_rs = '0;
  logic [31:0] ex_rt = '0;
  logic        ex_flush = 1'b0;
  logic        pipe_hold = 1'b0;
  logic        div_done = 1'b0;
  logic [31:0] div_quotient = '0;
  logic [31:0] div_remainder = '0;
  logic        div_begin, div_sign, div_dividend_sign, div_stall, res_valid, div_timeout;
  logic [31:0] div_dividend, div_divisor, res_hi, res_lo;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          done_at = -1;
  bit          suppress = 1'b0;
  logic [31:0] dq = '0;
  logic [31:0] dr = '0;

  div_issue_ctrl #(.DIV_CYCLE(DIVC), .WD_SLACK(SLACK)) dut (
    .clk               (clk),
    .rst               (rst),
    .ex_div_valid      (ex_div_valid),
    .ex_div_signed     (ex_div_signed),
    .ex_rs             (ex_rs),
    .ex_rt             (ex_rt),
    .ex_flush          (ex_flush),
    .pipe_hold         (pipe_hold),
    .div_done          (div_done),
    .div_quotient      (div_quotient),
    .div_remainder     (div_remainder),
    .div_begin         (div_begin),
    .div_sign          (div_sign),
    .div_dividend_sign (div_dividend_sign),
    .div_dividend      (div_dividend),
    .div_divisor       (div_divisor),
    .div_stall         (div_stall),
    .res_valid         (res_valid),
    .res_hi            (res_hi),
    .res_lo            (res_lo),
    .div_timeout       (div_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_time_limit reached at cyc=%0d", cyc);
    $fatal(1);
  end

  // {remainder, quotient} by truncating division, as the ISA defines it.
  function automatic logic [63:0] ref_div(input logic [31:0] rs, input logic [31:0] rt, input logic sgn);
    int sa, sb;
    if (sgn) begin
      sa = $signed(rs);
      sb = $signed(rt);
      return {32'(sa % sb), 32'(sa / sb)};
    end
    return {rs % rt, rs / rt};
  endfunction

  function automatic logic [31:0] mag_ref(input logic [31:0] x, input logic sgn);
    if (sgn && ($signed(x) < 0)) return 32'(0 - $signed(x));
    return x;
  endfunction

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Divider emulation plus settle: done arrives DIVC+1 cycles after begin is seen.
  task automatic settle();
    logic [31:0] a, b, q, r;
    div_done      = (cyc == done_at) && !suppress;
    div_quotient  = div_done ? dq : $urandom;
    div_remainder = div_done ? dr : $urandom;
    #1;
    if (rst) begin
      done_at = -1;
    end else if (div_begin) begin
      a = div_dividend;
      b = div_divisor;
      if (b == 0) begin
        q = '1;
        r = a;
      end else begin
        q = a / b;
        r = a % b;
      end
      dq = div_sign ? (32'd0 - q) : q;
      dr = div_dividend_sign ? (32'd0 - r) : r;
      done_at = cyc + DIVC + 1;
    end
  endtask

  task automatic idle_cycle(input string nm);
    ex_div_valid = 1'b0;
    ex_flush     = 1'b0;
    pipe_hold    = 1'b0;
    settle();
    total++;
    if ({div_begin, div_stall, res_valid} !== 3'b000) begin
      bad++;
      $display("FAIL %s idle {begin,stall,rv} got=%b want=000", nm, {div_begin, div_stall, res_valid});
    end
    adv();
  endtask

  task automatic run_div(input logic [31:0] rs, input logic [31:0] rt, input logic sgn, input string nm);
    logic [63:0] exp;
    logic [31:0] want_hi, want_lo;
    exp = (rt != 0) ? ref_div(rs, rt, sgn) : 64'd0;
    for (int c = 0; c <= DONE_C; c++) begin
      ex_div_valid  = 1'b1;
      ex_flush      = 1'b0;
      pipe_hold     = 1'b0;
      ex_div_signed = (c == 0) ? sgn : 1'($urandom);
      ex_rs         = (c == 0) ? rs : $urandom;
      ex_rt         = (c == 0) ? rt : $urandom;
      settle();
      total++;
      if (div_begin !== (c == 1)) begin
        bad++;
        $display("FAIL %s begin c=%0d got=%b want=%b", nm, c, div_begin, (c == 1));
      end
      total++;
      if (div_stall !== (c < DONE_C)) begin
        bad++;
        $display("FAIL %s stall c=%0d got=%b want=%b", nm, c, div_stall, (c < DONE_C));
      end
      total++;
      if (res_valid !== (c == DONE_C)) begin
        bad++;
        $display("FAIL %s res_valid c=%0d got=%b want=%b", nm, c, res_valid, (c == DONE_C));
      end
      if (c == 1 || c == 20) begin
        total++;
        if ({div_dividend, div_divisor, div_sign, div_dividend_sign} !==
            {mag_ref(rs, sgn), mag_ref(rt, sgn), sgn & (rs[31] ^ rt[31]), sgn & rs[31]}) begin
          bad++;
          $display("FAIL %s operands c=%0d got=%h/%h s=%b ds=%b want=%h/%h s=%b ds=%b", nm, c,
                   div_dividend, div_divisor, div_sign, div_dividend_sign,
                   mag_ref(rs, sgn), mag_ref(rt, sgn), sgn & (rs[31] ^ rt[31]), sgn & rs[31]);
        end
      end
      if (c == DONE_C) begin
        want_lo = (rt != 0) ? exp[31:0] : div_quotient;
        want_hi = (rt != 0) ? exp[63:32] : div_remainder;
        total++;
        if ({res_hi, res_lo} !== {want_hi, want_lo}) begin
          bad++;
          $display("FAIL %s result hi/lo got=%h/%h want=%h/%h", nm, res_hi, res_lo, want_hi, want_lo);
        end
        total++;
        if (div_timeout !== 1'b0) begin
          bad++;
          $display("FAIL %s timeout got=%b want=0", nm, div_timeout);
        end
      end
      adv();
    end
  endtask

  // First DIV flushed at cycle fc; second DIVU presented from cycle s2.
  task automatic run_flush(input int fc, input int s2, input string nm);
    logic [31:0] rs1, rt1, rs2, rt2;
    logic [63:0] exp2;
    int issue2, done2;
    bit w_stall, w_begin, w_rv;
    rs1    = $urandom;
    rt1    = $urandom_range(1, 1000);
    rs2    = $urandom;
    rt2    = $urandom_range(1, 1000);
    exp2   = {rs2 % rt2, rs2 / rt2};
    issue2 = (s2 > DONE_C) ? s2 : DONE_C + 1;
    done2  = issue2 + DONE_C;
    for (int c = 0; c <= done2; c++) begin
      ex_flush  = (c == fc);
      pipe_hold = 1'b0;
      if (c <= fc) begin
        ex_div_valid = 1'b1; ex_div_signed = 1'b0; ex_rs = rs1; ex_rt = rt1;
      end else if (c < s2) begin
        ex_div_valid = 1'b0; ex_div_signed = 1'($urandom); ex_rs = $urandom; ex_rt = $urandom;
      end else begin
        ex_div_valid  = 1'b1;
        ex_div_signed = (c <= issue2) ? 1'b0 : 1'($urandom);
        ex_rs         = (c <= issue2) ? rs2 : $urandom;
        ex_rt         = (c <= issue2) ? rt2 : $urandom;
      end
      settle();
      w_stall = (c <= fc) || (c >= s2 && c < done2);
      w_begin = (c == 1) || (c == issue2 + 1);
      w_rv    = (c == done2);
      total++;
      if (div_begin !== w_begin) begin
        bad++;
        $display("FAIL %s begin c=%0d got=%b want=%b", nm, c, div_begin, w_begin);
      end
      total++;
      if (div_stall !== w_stall) begin
        bad++;
        $display("FAIL %s stall c=%0d got=%b want=%b", nm, c, div_stall, w_stall);
      end
      total++;
      if (res_valid !== w_rv) begin
        bad++;
        $display("FAIL %s res_valid c=%0d got=%b want=%b", nm, c, res_valid, w_rv);
      end
      if (c == done2) begin
        total++;
        if ({res_hi, res_lo} !== exp2) begin
          bad++;
          $display("FAIL %s result hi/lo got=%h/%h want=%h/%h", nm, res_hi, res_lo, exp2[63:32], exp2[31:0]);
        end
      end
      adv();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ex_div_valid = 1'b0;
    adv();
    adv();
    settle();
    total++;
    if ({div_begin, div_stall, res_valid, div_timeout, div_sign, div_dividend_sign} !== 6'b0 ||
        {div_dividend, div_divisor, res_hi, res_lo} !== 128'd0) begin
      bad++;
      $display("FAIL reset_outputs got flags=%b dvd=%h dvs=%h hi=%h lo=%h want all 0",
               {div_begin, div_stall, res_valid, div_timeout, div_sign, div_dividend_sign},
               div_dividend, div_divisor, res_hi, res_lo);
    end
    ex_div_valid = 1'b1;
    settle();
    total++;
    if (div_stall !== 1'b0) begin
      bad++;
      $display("FAIL reset_stall_gated got=%b want=0", div_stall);
    end
    ex_div_valid = 1'b0;
    rst = 1'b0;
    adv();
    idle_cycle("after_reset");
  endtask

  task automatic test_divu_basic();
    run_div(32'd100, 32'd7, 1'b0, "divu_100_7");
    idle_cycle("divu_100_7");
  endtask

  task automatic test_div_signed();
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, "div_m7_2");
    idle_cycle("div_m7_2");
  endtask

  task automatic test_boundary();
    run_div(32'h8000_0000, 32'd3, 1'b1, "div_minint_3");
    run_div(32'h8000_0000, 32'd1, 1'b1, "div_minint_1");
    run_div(32'h8000_0000, 32'h8000_0000, 1'b0, "divu_8000_8000");
    run_div(32'd12345, 32'd0, 1'b0, "divu_by_zero");
    run_div(32'hFFFF_FFF0, 32'd0, 1'b1, "div_by_zero");
    idle_cycle("boundary");
  endtask

  task automatic test_back_to_back();
    logic [31:0] rs, rt;
    logic sgn;
    for (int i = 0; i < 6; i++) begin
      rs  = $urandom;
      rt  = (i % 2 == 1) ? 32'($urandom_range(1, 255)) : $urandom;
      sgn = 1'($urandom);
      if (rt == 0) rt = 32'd1;
      if (sgn && rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) rt = 32'd2;
      run_div(rs, rt, sgn, $sformatf("rand%0d", i));
      if (i % 3 == 2) idle_cycle("rand_gap");
    end
    idle_cycle("rand_end");
  endtask

  task automatic test_flush_drain();
    run_flush(10, 20, "flush_drain");
    idle_cycle("flush_drain");
  endtask

  task automatic test_flush_with_done();
    run_flush(DONE_C, DONE_C + 1, "flush_done");
    idle_cycle("flush_done");
  endtask

  task automatic test_hold();
    logic [31:0] rs, rt;
    logic [63:0] exp;
    bit w_rv;
    rs  = $urandom | 32'h8000_0000;
    rt  = 32'($urandom_range(3, 5000));
    exp = ref_div(rs, rt, 1'b1);
    for (int c = 0; c <= DONE_C + 4; c++) begin
      ex_div_valid  = 1'b1;
      ex_flush      = 1'b0;
      pipe_hold     = (c >= DONE_C) && (c <= DONE_C + 3);
      ex_div_signed = (c == 0) ? 1'b1 : 1'($urandom);
      ex_rs         = (c == 0) ? rs : $urandom;
      ex_rt         = (c == 0) ? rt : $urandom;
      settle();
      w_rv = (c == DONE_C + 4);
      total++;
      if (div_begin !== (c == 1)) begin
        bad++;
        $display("FAIL hold begin c=%0d got=%b want=%b", c, div_begin, (c == 1));
      end
      total++;
      if (div_stall !== (c < DONE_C)) begin
        bad++;
        $display("FAIL hold stall c=%0d got=%b want=%b", c, div_stall, (c < DONE_C));
      end
      total++;
      if (res_valid !== w_rv) begin
        bad++;
        $display("FAIL hold res_valid c=%0d got=%b want=%b", c, res_valid, w_rv);
      end
      if (w_rv) begin
        total++;
        if ({res_hi, res_lo} !== exp) begin
          bad++;
          $display("FAIL hold result hi/lo got=%h/%h want=%h/%h", res_hi, res_lo, exp[63:32], exp[31:0]);
        end
      end
      adv();
    end
    idle_cycle("hold_no_reissue");
  endtask

  task automatic test_timeout_reset();
    suppress = 1'b1;
    for (int c = 0; c <= WD_C + 5; c++) begin
      ex_div_valid  = 1'b1;
      ex_flush      = 1'b0;
      pipe_hold     = 1'b0;
      ex_div_signed = 1'b0;
      ex_rs         = 32'd500;
      ex_rt         = 32'd9;
      settle();
      total++;
      if (div_timeout !== (c >= WD_C)) begin
        bad++;
        $display("FAIL timeout c=%0d got=%b want=%b", c, div_timeout, (c >= WD_C));
      end
      if (c > 0) begin
        total++;
        if (div_stall !== 1'b1) begin
          bad++;
          $display("FAIL timeout_stall c=%0d got=%b want=1", c, div_stall);
        end
      end
      adv();
    end
    rst = 1'b1;
    ex_div_valid = 1'b0;
    settle();
    adv();
    rst = 1'b0;
    suppress = 1'b0;
    settle();
    total++;
    if ({div_begin, div_stall, res_valid, div_timeout, div_sign, div_dividend_sign} !== 6'b0 ||
        {div_dividend, div_divisor, res_hi, res_lo} !== 128'd0) begin
      bad++;
      $display("FAIL mid_busy_reset got flags=%b dvd=%h dvs=%h hi=%h lo=%h want all 0",
               {div_begin, div_stall, res_valid, div_timeout, div_sign, div_dividend_sign},
               div_dividend, div_divisor, res_hi, res_lo);
    end
    adv();
    run_div(32'd81, 32'd9, 1'b0, "post_reset");
    idle_cycle("post_reset");
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_div_signed();
    test_boundary();
    test_back_to_back();
    test_flush_drain();
    test_hold();
    test_flush_with_done();
    test_timeout_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
